add_result_buffer: RTL and testbench
====================================

Name: add_result_buffer

Overview:
- Downstream stage of the 8-bit ripple-carry adder. Captures each result word (8 sum bits plus final carry-out) offered with a valid/ready handshake.
- Buffers results in a small FIFO and presents them to the consumer with a registered valid/ready interface.
- Keeps a saturating count of results that carried out of the MSB.
- Decouples the combinational adder from a consumer that may stall.

Parameters:
- WIDTH, 8, sum width in bits; matches the adder datapath.
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the carry-event counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  adder result presented this cycle.
- in_ready  output  1  buffer can accept; equals not-full, combinational from occupancy only.
- in_sum  input  WIDTH  sum bits; bit 0 is the LSB stage.
- in_carry  input  1  carry-out of the MSB stage.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_sum  output  WIDTH  head entry sum.
- out_carry  output  1  head entry carry.
- clear  input  1  synchronous clear of carry_count only.
- carry_count  output  CNT_W  number of accepted results with in_carry=1; saturates.

Behaviour:
- Reset (rst_n low, asynchronous): occupancy 0, read and write pointers 0, out_valid 0, out_sum 0, out_carry 0, carry_count 0. in_ready reads 1 while in reset.
- Push: when in_valid and in_ready are both 1 at an edge, {in_carry, in_sum} is written at the write pointer. The pointer wraps modulo DEPTH.
- Pop: when out_valid and out_ready are both 1 at an edge, the head entry is consumed. The read pointer wraps modulo DEPTH.
- Latency: a word pushed into an empty buffer appears with out_valid=1 on the cycle after acceptance. There is no same-cycle pass-through.
- Simultaneous push and pop, partially filled: occupancy is unchanged and both pointers advance.
- Simultaneous push and pop, full: no push, because in_ready=0. A pop that cycle frees a slot, and in_ready rises on the next cycle.
- Empty: out_valid=0. out_sum and out_carry hold the last popped value, or 0 after reset. out_ready is ignored.
- Full (occupancy == DEPTH): in_ready=0. in_valid is ignored and in_sum/in_carry are not sampled.
- Outputs: out_valid, out_sum and out_carry are registered. The head entry is stable while out_valid=1 and out_ready=0.
- carry_count increments by 1 on each accepted push with in_carry=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - Pops do not affect it.
- clear: carry_count becomes 0 at the next edge. If clear coincides with a carrying push, clear wins and the result is 0.
- Reset mid-operation discards all buffered entries immediately. No partial state survives.
- Upstream is not required to hold in_valid; unaccepted words are simply dropped by the producer's choice.

Optional Feature:
- Macro: ADD_RESULT_ZERO_FLAG_EN.
- Defined:
  - Adds output port out_zero (1 bit).
  - out_zero is registered alongside the head entry and is 1 when the head out_sum == 0 and out_carry == 0.
  - It is 0 when out_valid=0 and 0 after reset.
  - It is computed at push time and stored as an extra FIFO bit.
- Undefined: the port and the storage bit do not exist. All other behaviour is identical.

Decomposition:
- Shared package add_pkg:
  - ADD_WIDTH constant (8).
  - Packed struct add_result_t {carry, sum[ADD_WIDTH-1:0]}, used for FIFO storage and shared with the adder wrapper.
- Sub-module sat_counter: parameter CNT_W; inputs inc and clr (clr has priority); output cnt. Instantiated once for carry_count.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset then idle: rst_n low mid-run with 2 entries buffered -> out_valid=0, out_sum=0, carry_count=0 and in_ready=1 immediately, without waiting for a clock edge.
- Single push, out_ready=1: push sum=0x5A, carry=0 -> next cycle out_valid=1, out_sum=0x5A, out_carry=0; popped, then out_valid=0.
- Fill and stall, out_ready=0: push 0x01, then 0xFF with carry=1 -> in_ready=0 after the 2nd push; 3rd in_valid word is ignored. Release -> outputs 0x01 then 0xFF/1 in order. carry_count=1.
- Throughput: continuous in_valid and out_ready=1 for 16 words 0x00..0x0F -> one word per cycle, in order, no bubbles after the first.
- Saturation and clear, CNT_W=2: 5 carrying pushes -> carry_count=3. clear together with a carrying push -> 0. Next carrying push -> 1.
- With ADD_RESULT_ZERO_FLAG_EN: push sum=0x00/carry=0 -> out_zero=1. Push 0x00/carry=1 -> out_zero=0. Empty -> out_zero=0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types for the 8-bit adder datapath and its result buffer.
// A result word is the sum plus the carry out of the MSB stage.
package add_pkg;

    localparam int ADD_WIDTH = 8;

    typedef struct packed {
        logic                 carry;
        logic [ADD_WIDTH-1:0] sum;
    } add_result_t;

    function automatic logic is_zero(input add_result_t r);
        return (r.carry == 1'b0) && (r.sum == '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/add_result_buffer.sv
// Result FIFO behind the ripple-carry adder with registered head outputs.
// Define ADD_RESULT_ZERO_FLAG_EN to add the out_zero head flag.
module add_result_buffer
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    input  logic             clear,
    output logic [CNT_W-1:0] carry_count
`ifdef ADD_RESULT_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam int PW = $clog2(DEPTH);

    add_result_t       mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_next;
    logic [PW:0]       count;
    logic [PW:0]       count_next;
    logic              push;
    logic              pop;
    logic              valid_next;
    logic              bypass;
    add_result_t       in_word;
    add_result_t       head_next;

    assign in_word.carry = in_carry;
    assign in_word.sum   = in_sum;

    assign in_ready = (count != (PW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign rd_next    = rd_ptr + PW'(pop);
    assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);
    assign valid_next = (count_next != '0);

    // The incoming word becomes the head only when nothing else remains.
    assign bypass    = push && (wr_ptr == rd_next);
    assign head_next = bypass ? in_word : mem[rd_next];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= valid_next;
            if (valid_next) begin
                out_sum   <= head_next.sum;
                out_carry <= head_next.carry;
            end
        end
    end

`ifdef ADD_RESULT_ZERO_FLAG_EN
    logic zmem [DEPTH];
    logic zero_next;

    assign zero_next = bypass ? is_zero(in_word) : zmem[rd_next];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                zmem[i] <= 1'b0;
            end
            out_zero <= 1'b0;
        end else begin
            if (push) begin
                zmem[wr_ptr] <= is_zero(in_word);
            end
            out_zero <= valid_next && zero_next;
        end
    end
`endif

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_carry_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (push && in_carry),
        .clr  (clear),
        .cnt  (carry_count)
    );

endmodule

// File: tb/tb_add_result_buffer.sv
// Scoreboard bench for add_result_buffer, built with a 2-bit carry counter.
module tb_add_result_buffer;

    localparam int W   = 8;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sum;
    logic          in_carry;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_carry;
    logic          clear;
    logic [CW-1:0] carry_count;
`ifdef ADD_RESULT_ZERO_FLAG_EN
    logic          out_zero;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [W+1:0] q[$];

    add_result_buffer #(
        .WIDTH(W),
        .DEPTH(2),
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carry  (out_carry),
        .clear      (clear),
        .carry_count(carry_count)
`ifdef ADD_RESULT_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] pack(input logic [W-1:0] s,
                                         input logic c);
        logic z;
        z = (s == 8'h00) && !c;
        return {z, c, s};
    endfunction

    // Present one word for one cycle; acc is whether it must be taken.
    task automatic drive(input logic [W-1:0] s, input logic c,
                         input bit acc, input bit clr = 1'b0);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        clear    = clr;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, acc});
        if (acc) q.push_back(pack(s, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [W+1:0] e;
            pops++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h/%0b expected none",
                         out_sum, out_carry);
            end else begin
                e = q.pop_front();
                chk("out_sum", {24'd0, out_sum}, {24'd0, e[W-1:0]});
                chk("out_carry", {31'd0, out_carry}, {31'd0, e[W]});
`ifdef ADD_RESULT_ZERO_FLAG_EN
                chk("out_zero", {31'd0, out_zero}, {31'd0, e[W+1]});
`endif
            end
        end
    end

    initial begin
        int p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
        chk("rst_count", {30'd0, carry_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // single word, pops one cycle after acceptance
        out_ready = 1'b1;
        drive(8'h5A, 1'b0, 1'b1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        idle(1);
        chk("empty_valid", {31'd0, out_valid}, 32'd0);
        chk("empty_hold", {24'd0, out_sum}, 32'h5A);

        // fill and stall
        out_ready = 1'b0;
        drive(8'h01, 1'b0, 1'b1);
        drive(8'hFF, 1'b1, 1'b1);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_head", {24'd0, out_sum}, 32'h01);
        drive(8'h33, 1'b0, 1'b0);
        chk("stall_head2", {24'd0, out_sum}, 32'h01);
        chk("fill_count", {30'd0, carry_count}, 32'd1);
        out_ready = 1'b1;
        idle(3);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // full with simultaneous pop: push refused, ready next cycle
        out_ready = 1'b0;
        drive(8'h21, 1'b0, 1'b1);
        drive(8'h22, 1'b1, 1'b1);
        out_ready = 1'b1;
        drive(8'h23, 1'b0, 1'b0);
        chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
        drive(8'h24, 1'b0, 1'b1);
        idle(2);
        chk("count_two", {30'd0, carry_count}, 32'd2);

        // back-to-back throughput
        p0 = pops;
        for (int i = 0; i < 16; i++) drive(W'(i), 1'b0, 1'b1);
        idle(1);
        chk("thru_pops", pops - p0, 32'd16);
        chk("thru_end_valid", {31'd0, out_valid}, 32'd0);

        // saturation and clear priority
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clear_only", {30'd0, carry_count}, 32'd0);
        for (int i = 0; i < 5; i++) drive(W'(8'h10 + i), 1'b1, 1'b1);
        chk("saturate", {30'd0, carry_count}, 32'd3);
        drive(8'h55, 1'b1, 1'b1, 1'b1);
        chk("clear_wins", {30'd0, carry_count}, 32'd0);
        drive(8'h56, 1'b1, 1'b1);
        chk("after_clear", {30'd0, carry_count}, 32'd1);
        idle(2);

`ifdef ADD_RESULT_ZERO_FLAG_EN
        out_ready = 1'b0;
        drive(8'h00, 1'b0, 1'b1);
        chk("zero_set", {31'd0, out_zero}, 32'd1);
        out_ready = 1'b1;
        idle(1);
        drive(8'h00, 1'b1, 1'b1);
        chk("zero_carry", {31'd0, out_zero}, 32'd0);
        idle(1);
        chk("zero_empty", {31'd0, out_zero}, 32'd0);
`endif

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(8'hA1, 1'b1, 1'b1);
        drive(8'hA2, 1'b0, 1'b1);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sum", {24'd0, out_sum}, 32'd0);
        chk("arst_count", {30'd0, carry_count}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        drive(8'h99, 1'b0, 1'b1);
        idle(2);
        chk("queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
